// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Data wins ties until it has taken MAX_DM_STREAK grants in a row; stuck requests time out.
module mem_port_arbiter #(
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_dm,
    output logic        bus_err
);
    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 2);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mem_valid;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [STREAK_W-1:0] r_streak;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic w_grant_if;
    logic w_grant_dm;
    logic w_finish;
    logic w_complete;
    logic w_timeout;
    logic w_streak_full;

    // A ready in the timeout cycle still counts as a normal completion.
    assign w_complete    = r_mem_valid & mem_ready;
    assign w_timeout     = r_mem_valid & ~mem_ready & (r_tmo_cnt == TMO_W'(TIMEOUT_CYC));
    assign w_streak_full = (r_streak >= STREAK_W'(MAX_DM_STREAK));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req && !(if_req && w_streak_full)) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = DM_BUSY;
                end else if (if_req) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (w_complete || w_timeout) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory request launch; fields stay frozen until the transaction ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_dm) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
        end else if (w_grant_if) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
        end else if (w_finish) begin
            r_mem_valid <= 1'b0;
        end
    end

    // Consecutive data grants, saturating at the fairness threshold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_grant_if) begin
            r_streak <= '0;
        end else if (w_grant_dm && !w_streak_full) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    // Cycles spent waiting on mem_ready for the current transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_grant_if || w_grant_dm) begin
            r_tmo_cnt <= '0;
        end else if (r_mem_valid && !mem_ready && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign if_done  = (w_complete | w_timeout) & (r_state == IF_BUSY);
    assign dm_done  = (w_complete | w_timeout) & (r_state == DM_BUSY);
    assign if_rdata = (if_done && w_complete) ? mem_rdata : 32'd0;
    assign dm_rdata = (dm_done && w_complete) ? mem_rdata : 32'd0;
    assign bus_err  = w_timeout;
    assign stall_if = if_req & ~if_done;
    assign stall_dm = dm_req & ~dm_done;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Parameters
REQ-001 SHALL have parameter MAX_DM_STREAK, default 4, the number of consecutive data grants after which a pending fetch wins.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, the number of mem_valid cycles without mem_ready before the transaction is aborted.

Interface
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port if_req, input, 1, fetch request, held until if_done.
REQ-006 SHALL have port if_addr, input, 32, fetch address.
REQ-007 SHALL have ports if_rdata (output, 32, fetch read data) and if_done (output, 1, fetch completion).
REQ-008 SHALL have ports dm_req, input, 1; dm_we, input, 1; dm_addr, input, 32; dm_wdata, input, 32 (data-stage request, write enable, address, write data).
REQ-009 SHALL have ports dm_rdata (output, 32, load data) and dm_done (output, 1, data completion).
REQ-010 SHALL have ports mem_valid, mem_we (outputs, 1), mem_addr, mem_wdata (outputs, 32), the memory request.
REQ-011 SHALL have ports mem_ready (input, 1) and mem_rdata (input, 32), the memory response.
REQ-012 SHALL have ports stall_if, stall_dm, bus_err, all outputs, 1 bit: fetch stall, data stall and abort pulse.

Function
REQ-013 SHALL implement FSM states IDLE, IF_BUSY and DM_BUSY.
REQ-014 In IDLE with only one request high, SHALL grant that requester.
REQ-015 In IDLE with both requests high, SHALL grant data, unless dm_streak >= MAX_DM_STREAK, in which case SHALL grant fetch.
REQ-016 SHALL keep dm_streak as a saturating counter: +1 on each data grant, cleared on each fetch grant.
REQ-017 On a grant at edge t, SHALL register mem_addr, mem_we (0 for fetch), mem_wdata and mem_valid=1, so the request is visible in cycle t+1.
REQ-018 While mem_valid=1, SHALL hold mem_addr, mem_we and mem_wdata stable.
REQ-019 A completion occurs in a cycle with mem_valid & mem_ready; SHALL then assert the owner's done combinationally in that cycle.
REQ-020 On completion, SHALL drive the owner's rdata = mem_rdata, clear mem_valid and return to IDLE (one idle bubble between transactions).
REQ-021 if_rdata/dm_rdata SHALL be 0 when the corresponding done is 0.
REQ-022 SHALL drive stall_if = if_req & ~if_done and stall_dm = dm_req & ~dm_done, combinationally.
REQ-023 SHALL count cycles of mem_valid=1 without mem_ready, the counter being cleared on each grant.
REQ-024 When that count reaches TIMEOUT_CYC, SHALL pulse bus_err and the owner's done for one cycle, drive rdata=0, clear mem_valid and return to IDLE.
REQ-025 If mem_ready arrives in the same cycle the timeout is reached, SHALL treat it as a normal completion with no bus_err.
REQ-026 SHALL ignore mem_ready while mem_valid=0.
REQ-027 SHALL ignore request or address changes of the non-owner during a transaction.
REQ-028 A requester's req high in the cycle after its done SHALL be a new request.

Reset
REQ-029 reset SHALL asynchronously force state IDLE, all counters to 0, and mem_valid, mem_we, mem_addr and mem_wdata to 0.
REQ-030 reset SHALL force if_done, dm_done and bus_err to 0 and both rdata outputs to 0.
REQ-031 A reset mid-transaction SHALL abort it with no done pulse; after release, pending requests SHALL be re-arbitrated from IDLE.

Verification
REQ-032 if_req=1, if_addr=0x100 alone; mem_ready=1 two cycles after mem_valid -> mem_addr=0x100, mem_we=0, if_done pulses once with if_rdata=mem_rdata, back to IDLE.
REQ-033 dm_req and if_req both high in IDLE, dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF -> data granted first with mem_we=1, fetch granted after dm_done plus one bubble.
REQ-034 dm_req held high with new addresses and if_req held high -> 4 data grants then 1 fetch grant, pattern repeating.
REQ-035 Grant with mem_ready tied 0 -> bus_err and owner done pulse at TIMEOUT_CYC=255 cycles after mem_valid rises, rdata=0, mem_valid=0 the next cycle.
REQ-036 reset asserted while in DM_BUSY -> mem_valid=0 immediately, no dm_done; after release with dm_req still 1 -> new grant one cycle later.
REQ-037 mem_ready=1 in the same cycle mem_valid rises -> done that cycle, stall_if/stall_dm low only in that cycle.
